// File: rtl/mul_scheduler.sv
// Operand FIFO plus issue/collect FSM for the 8-step shift-add multiplier.
// Optional macro MUL_SCHED_TIMEOUT_EN adds a WAIT watchdog that sets the sticky err flag.
module mul_scheduler #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  op_a,
  input  logic [7:0]  op_b,
  input  logic        op_vld,
  output logic        op_rdy,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  output logic        mul_vld,
  input  logic [15:0] mul_res,
  input  logic        mul_res_rdy,
  output logic [15:0] out_res,
  output logic        out_vld,
  input  logic        out_rdy,
  output logic        err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
    $error("mul_scheduler: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  logic [15:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  state_t           state_q, state_d;
  logic [7:0]       mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic             mul_vld_q, mul_vld_d;
  logic [15:0]      out_res_q, out_res_d;
  logic             out_vld_q, out_vld_d;
  logic             push, pop;

`ifdef MUL_SCHED_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
`endif

  // Full blocks the push even when the FSM pops in the same cycle.
  assign op_rdy = !rst && (count_q < DEPTH_C);
  assign push   = op_vld && op_rdy;
  assign pop    = (state_q == IDLE) && (count_q != '0);

  always_comb begin
    wr_ptr_d  = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d   = count_q;
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push && pop) count_d = count_q - CNT_W'(1);

    state_d   = state_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    mul_vld_d = 1'b0;
    out_res_d = out_res_q;
    out_vld_d = out_vld_q;
`ifdef MUL_SCHED_TIMEOUT_EN
    tmo_d     = tmo_q;
    err_d     = err_q;
`endif

    case (state_q)
      IDLE: begin
        if (pop) begin
          {mul_a_d, mul_b_d} = mem_q[rd_ptr_q];
          mul_vld_d          = 1'b1;
          state_d            = ISSUE;
        end
      end
      ISSUE: begin
        // mul_res_rdy is still high from the multiplier's idle state here.
        state_d = WAIT;
`ifdef MUL_SCHED_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      WAIT: begin
        if (mul_res_rdy) begin
          out_res_d = mul_res;
          out_vld_d = 1'b1;
          state_d   = DONE;
        end
`ifdef MUL_SCHED_TIMEOUT_EN
        else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
`endif
      end
      DONE: begin
        if (out_vld_q && out_rdy) begin
          out_vld_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      state_q   <= IDLE;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      mul_vld_q <= 1'b0;
      out_res_q <= '0;
      out_vld_q <= 1'b0;
`ifdef MUL_SCHED_TIMEOUT_EN
      tmo_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      state_q   <= state_d;
      mul_a_q   <= mul_a_d;
      mul_b_q   <= mul_b_d;
      mul_vld_q <= mul_vld_d;
      out_res_q <= out_res_d;
      out_vld_q <= out_vld_d;
`ifdef MUL_SCHED_TIMEOUT_EN
      tmo_q     <= tmo_d;
      err_q     <= err_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {op_a, op_b};
  end

  assign mul_a   = mul_a_q;
  assign mul_b   = mul_b_q;
  assign mul_vld = mul_vld_q;
  assign out_res = out_res_q;
  assign out_vld = out_vld_q;
`ifdef MUL_SCHED_TIMEOUT_EN
  assign err     = err_q;
`else
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_mul_scheduler.sv
// Scoreboard bench for mul_scheduler with an 8-step multiplier stub.
module tb_mul_scheduler;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  op_a, op_b, mul_a, mul_b;
  logic        op_vld, op_rdy, mul_vld, mul_res_rdy, out_vld, out_rdy, err;
  logic [15:0] mul_res, out_res;

  mul_scheduler #(.DEPTH(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .op_a(op_a), .op_b(op_b), .op_vld(op_vld), .op_rdy(op_rdy),
    .mul_a(mul_a), .mul_b(mul_b), .mul_vld(mul_vld), .mul_res(mul_res),
    .mul_res_rdy(mul_res_rdy), .out_res(out_res), .out_vld(out_vld), .out_rdy(out_rdy),
    .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier stub: busy for 8 cycles after the load pulse; m_stall keeps it from finishing.
  logic [3:0]  m_cnt;
  logic [15:0] m_res;
  logic        m_stall;
  always @(posedge clk) begin
    if (rst) begin
      m_cnt <= '0;
      m_res <= '0;
    end else if (mul_vld) begin
      m_cnt <= 4'd8;
      m_res <= 16'(mul_a) * 16'(mul_b);
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 4'd1;
    end
  end
  assign mul_res_rdy = (m_cnt == 0) && !m_stall;
  assign mul_res     = m_res;

  logic [15:0] exp_q[$];
  int n_chk = 0, n_fail = 0;
  int n_mulvld = 0, mulvld_cyc = -1, outvld_cyc = -1;
  logic p_mul_vld = 0, p_out_vld = 0, p_out_rdy = 0;
  logic [15:0] p_out_res = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: scoreboard pops on each output handshake, plus hold and pulse-width rules.
  always @(negedge clk) begin
    if (!rst) begin
      if (mul_vld) begin
        n_mulvld++;
        mulvld_cyc = cyc;
        check("mul_vld_single_cycle", p_mul_vld, 1'b0);
      end
      if (out_vld && !p_out_vld) outvld_cyc = cyc;
      if (p_out_vld && !p_out_rdy) begin
        check("out_vld_hold", out_vld, 1'b1);
        check("out_res_hold", out_res, p_out_res);
      end
      if (out_vld && out_rdy) begin
        if (exp_q.size() == 0) check("unexpected_out_vld", out_vld, 1'b0);
        else check("out_res", out_res, exp_q.pop_front());
      end
    end
    p_mul_vld = rst ? 1'b0 : mul_vld;
    p_out_vld = rst ? 1'b0 : out_vld;
    p_out_rdy = out_rdy;
    p_out_res = out_res;
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [15:0] e,
                      input bit track, input int max_wait, output bit ok, output int acc);
    op_a = a; op_b = b; op_vld = 1'b1; ok = 1'b0; acc = -1;
    for (int i = 0; i < max_wait && !ok; i++) begin
      @(negedge clk);
      if (op_rdy) begin
        ok  = 1'b1;
        acc = cyc;
        if (track) exp_q.push_back(e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic drain(input int max_cyc);
    bit done = 1'b0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_vld) done = 1'b1;
    end
    check("drain_in_time", done, 1'b1);
    @(posedge clk); #1;
  endtask

  bit ok;
  int t0, t1, n0, h;
  bit seen;

  initial begin
    rst = 1'b1; op_vld = 1'b0; op_a = '0; op_b = '0; out_rdy = 1'b1; m_stall = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_op_rdy", op_rdy, 1'b0);
    check("rst_mul_vld", mul_vld, 1'b0);
    check("rst_out_vld", out_vld, 1'b0);
    check("rst_out_res", out_res, 16'h0);
    check("rst_mul_ab", {mul_a, mul_b}, 16'h0);
    check("rst_err", err, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("post_rst_op_rdy", op_rdy, 1'b1);

    // Single op: latency of issue and result.
    n0 = n_mulvld;
    send(8'd13, 8'd11, 16'h008F, 1, 5, ok, t0);
    op_vld = 1'b0;
    check("single_accept", ok, 1'b1);
    drain(60);
    check("single_mul_vld_cycle", mulvld_cyc, t0 + 2);
    check("single_out_vld_cycle", outvld_cyc, t0 + 12);
    check("single_issue_count", n_mulvld - n0, 1);

    // Extremes back to back.
    n0 = n_mulvld;
    send(8'd255, 8'd255, 16'hFE01, 1, 5, ok, t0); check("ext_accept0", ok, 1'b1);
    send(8'd0,   8'd200, 16'h0000, 1, 5, ok, t0); check("ext_accept1", ok, 1'b1);
    send(8'd1,   8'd1,   16'h0001, 1, 5, ok, t0); check("ext_accept2", ok, 1'b1);
    op_vld = 1'b0;
    drain(100);
    check("ext_issue_count", n_mulvld - n0, 3);

    // FIFO full with downstream stalled.
    out_rdy = 1'b0;
    n0 = n_mulvld;
    send(8'd2,  8'd3,  16'h0006, 1, 3, ok, t0); check("full_accept0", ok, 1'b1);
    send(8'd4,  8'd5,  16'h0014, 1, 3, ok, t1); check("full_accept1", ok, 1'b1);
    send(8'd6,  8'd7,  16'h002A, 1, 3, ok, t1); check("full_accept2", ok, 1'b1);
    send(8'd8,  8'd9,  16'h0048, 1, 3, ok, t1); check("full_accept3", ok, 1'b1);
    send(8'd10, 8'd12, 16'h0078, 1, 3, ok, t1); check("full_accept4", ok, 1'b1);
    send(8'd15, 8'd15, 16'h00E1, 1, 20, ok, t1);
    check("full_sixth_blocked", ok, 1'b0);
    op_vld = 1'b0;
    @(negedge clk);
    check("full_op_rdy", op_rdy, 1'b0);
    check("full_issue_count", n_mulvld - n0, 1);
    check("full_out_vld", out_vld, 1'b1);
    check("full_out_res_head", out_res, 16'h0006);
    @(posedge clk); #1 out_rdy = 1'b1;
    drain(200);
    check("full_total_issues", n_mulvld - n0, 5);

    // Backpressure for 20 cycles, then next issue two cycles after the handshake.
    out_rdy = 1'b0;
    send(8'd7, 8'd9, 16'h003F, 1, 5, ok, t0); check("bp_accept0", ok, 1'b1);
    send(8'd2, 8'd2, 16'h0004, 1, 5, ok, t1); check("bp_accept1", ok, 1'b1);
    op_vld = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (out_vld) seen = 1'b1;
    end
    check("bp_out_vld_seen", seen, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    check("bp_out_vld_held", out_vld, 1'b1);
    out_rdy = 1'b1;
    h = cyc;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (mul_vld) seen = 1'b1;
    end
    check("bp_next_issue_cycle", seen ? cyc : -1, h + 2);
    drain(60);

    // Reset while the first pair is in WAIT and a second is buffered.
    n0 = n_mulvld;
    send(8'd13, 8'd11, 16'h0, 0, 5, ok, t0); check("rst_case_accept0", ok, 1'b1);
    send(8'd9,  8'd9,  16'h0, 0, 5, ok, t1); check("rst_case_accept1", ok, 1'b1);
    op_vld = 1'b0;
    while (cyc < t0 + 6) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_op_rdy", op_rdy, 1'b0);
    check("mid_rst_issue_count", n_mulvld - n0, 1);
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b0;
    n0 = n_mulvld;
    repeat (30) @(posedge clk);
    #1;
    check("after_rst_no_issue", n_mulvld - n0, 0);
    check("after_rst_out_vld", out_vld, 1'b0);
    check("after_rst_op_rdy", op_rdy, 1'b1);
    send(8'd3, 8'd5, 16'h000F, 1, 5, ok, t0); check("after_rst_accept", ok, 1'b1);
    op_vld = 1'b0;
    drain(60);

`ifdef MUL_SCHED_TIMEOUT_EN
    // Stalled multiplier trips the watchdog after 16 WAIT cycles.
    m_stall = 1'b1;
    send(8'd5, 8'd5, 16'h0, 0, 5, ok, t0); check("tmo_accept", ok, 1'b1);
    op_vld = 1'b0;
    while (cyc < t0 + 18) @(negedge clk);
    check("tmo_err_before", err, 1'b0);
    @(negedge clk);
    check("tmo_err_set", err, 1'b1);
    @(posedge clk); #1 m_stall = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("tmo_err_sticky", err, 1'b1);
    check("tmo_no_out_vld", out_vld, 1'b0);
    send(8'd2, 8'd8, 16'h0010, 1, 5, ok, t0); check("tmo_recover_accept", ok, 1'b1);
    op_vld = 1'b0;
    drain(60);
    check("tmo_err_still", err, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("tmo_err_cleared", err, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mul_scheduler.md
Name: mul_scheduler

Overview:
Operand front-end and result back-end for the 8x8 shift-add multiplier, which takes 8 steps per product. Accepts operand pairs from upstream over valid/ready and buffers them in a small FIFO. Issues one pair at a time to the multiplier as a single-cycle valid pulse, waits for the multiplier's done flag, then presents the 16-bit product downstream over valid/ready.

Parameters:
DEPTH, 4, operand FIFO entries; power of 2, minimum 2.
TIMEOUT, 16, maximum cycles in WAIT before a timeout (used only with the optional feature).

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
op_a  input  8  upstream operand A
op_b  input  8  upstream operand B
op_vld  input  1  upstream operand pair valid
op_rdy  output  1  FIFO can accept a pair
mul_a  output  8  operand A to multiplier
mul_b  output  8  operand B to multiplier
mul_vld  output  1  one-cycle load pulse to multiplier
mul_res  input  16  product from multiplier
mul_res_rdy  input  1  multiplier idle/done
out_res  output  16  product to downstream
out_vld  output  1  product valid
out_rdy  input  1  downstream accepts product
err  output  1  sticky timeout flag; tied 0 when the feature is compiled out

Behaviour:
- Clock and reset: clk; reset rst, synchronous, active-high. The multiplier shares this rst.
- Reset values: op_rdy=0 during rst; mul_a=0, mul_b=0, mul_vld=0, out_res=0, out_vld=0, err=0. FIFO is emptied and FSM goes to IDLE.
- FIFO:
  - Push when op_vld && op_rdy. op_rdy = !rst && count<DEPTH.
  - When full, op_rdy=0 even if a pop occurs the same cycle.
  - Pointers wrap modulo DEPTH. Count width is clog2(DEPTH+1).
  - Simultaneous push and pop leaves count unchanged.
- FSM states: IDLE, ISSUE, WAIT, DONE. All outputs are registered.
  - IDLE: if FIFO non-empty, pop the head into mul_a/mul_b and go to ISSUE.
  - ISSUE: mul_vld=1 for exactly this one cycle; next state is WAIT. mul_res_rdy is ignored here because it is still 1 from the previous idle.
  - WAIT: mul_vld=0. When mul_res_rdy=1, capture mul_res into out_res, set out_vld=1 and go to DONE.
  - DONE: hold out_res and out_vld stable. On out_vld && out_rdy, clear out_vld and go to IDLE.
- mul_a/mul_b hold their values until the next pop.
- Timing, with an empty FIFO, IDLE state and out_rdy=1:
  - Pair accepted in cycle 0; popped in cycle 1; mul_vld high in cycle 2.
  - Multiplier raises mul_res_rdy in cycle 11; out_vld high in cycle 12.
  - Steady-state throughput is one product per 12 cycles.
- Upstream and downstream are independent: the FIFO keeps filling while the FSM is in WAIT or DONE.
- Only one multiplication is outstanding at any time; products leave in FIFO order.
- Reset mid-operation (any state): all state is discarded, no out_vld is produced for in-flight or buffered pairs, and the FSM restarts in IDLE.

Optional Feature:
Macro MUL_SCHED_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT with mul_res_rdy still 0, err is set (sticky until rst), the operation is dropped with no out_vld, and the FSM returns to IDLE.
- Not defined: no counter is built, err is constantly 0, and WAIT waits indefinitely.

Test Plan:
- Single op: op_a=13, op_b=11 with FIFO empty and out_rdy=1 -> mul_vld pulses in cycle 2 only; out_vld in cycle 12 with out_res=0x008F.
- Extremes: (255,255), then (0,200), then (1,1) back-to-back -> out_res sequence 0xFE01, 0x0000, 0x0001 in order; exactly one mul_vld pulse per pair.
- FIFO full, DEPTH=4: out_rdy=0 and 6 pairs offered continuously.
  - 1 pair is in flight and 4 are buffered, then op_rdy=0.
  - out_res stays stable while out_rdy=0, and no second mul_vld is issued until the DONE handshake.
  - Release out_rdy -> all 5 products delivered in order.
- Backpressure: hold out_rdy=0 for 20 cycles after out_vld -> out_res/out_vld unchanged; handshake on release; next mul_vld issued 2 cycles later.
- Reset mid-WAIT: assert rst in cycle 6 of the single-op case -> no out_vld ever appears, op_rdy=0 during rst, FIFO empty afterward; a new op (3,5) afterward yields 0x000F.
- Timeout (MUL_SCHED_TIMEOUT_EN, multiplier stubbed with mul_res_rdy forced 0 after issue) -> err=1 after 16 WAIT cycles, no out_vld, FSM back to IDLE, err held until rst.
